// File: rtl/spi_reg_pkg.sv
// Shared types and frame constants for the SPI register-frame controller.
// Frame layout, MSB first: {rw, addr[6:0], data[7:0]}.
package spi_reg_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timebase: one-cycle tick every CLK_DIV clk cycles.
// A synchronous clear restarts the count so each FSM state begins on a full half-period.
module spi_half_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = (cnt == 8'(CLK_DIV - 1));

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (!rst_n || clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 controller shifting 16-bit register frames out MSB first.
// Optional read-back capture of cipo is enabled by defining SPI_REG_MASTER_READBACK_EN.
module spi_reg_master
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_HALVES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              copi,
  output logic              ncs,
  input  logic              cipo,
  output logic [DATA_W-1:0] rdata
);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_reg_master: CLK_DIV must be within 1..255");
  end
  if (GAP_HALVES < 1 || GAP_HALVES > 63) begin : g_bad_gap
    $error("spi_reg_master: GAP_HALVES must be within 1..63");
  end

  localparam logic [5:0] LAST_HALF = 6'd31;
  localparam logic [5:0] GAP_LAST  = 6'(GAP_HALVES - 1);

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   shreg;
  logic [5:0]           half_cnt;
  logic                 sclk_q, copi_q, ncs_q, done_q;
  logic                 tick;

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_d != state_q),
    .tick  (tick)
  );

  // NOTE: state_d gets its default before the case so no path leaves it unassigned;
  // without that default this block would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (tick) state_d = SHIFT;
      SHIFT:   if (tick && half_cnt == LAST_HALF) state_d = HOLD;
      HOLD:    if (tick) state_d = GAP;
      GAP:     if (tick && half_cnt == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg    <= '0;
      half_cnt <= '0;
      sclk_q   <= 1'b0;
      copi_q   <= 1'b0;
      ncs_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          shreg    <= pack_frame(rw, addr, wdata);
          copi_q   <= rw;
          ncs_q    <= 1'b0;
          half_cnt <= '0;
        end
        SETUP: if (tick) sclk_q <= 1'b1;
        SHIFT: if (tick) begin
          half_cnt <= half_cnt + 1'b1;
          // Falling edge presents the next bit; the final low half gets no rising edge.
          if (sclk_q) begin
            sclk_q <= 1'b0;
            shreg  <= {shreg[FRAME_W-2:0], 1'b0};
            copi_q <= shreg[FRAME_W-2];
          end else if (half_cnt != LAST_HALF) begin
            sclk_q <= 1'b1;
          end
        end
        HOLD: if (tick) begin
          ncs_q    <= 1'b1;
          copi_q   <= 1'b0;
          half_cnt <= '0;
        end
        GAP: if (tick) begin
          half_cnt <= half_cnt + 1'b1;
          if (state_d == IDLE) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign sclk = sclk_q;
  assign copi = copi_q;
  assign ncs  = ncs_q;

`ifdef SPI_REG_MASTER_READBACK_EN
  // Rising edges 9..16 occur when leaving odd half-periods 15..29.
  localparam logic [5:0] CAP_FIRST = 6'd15;

  logic [DATA_W-1:0] cap_q, rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == SHIFT && tick && !sclk_q &&
          half_cnt != LAST_HALF && half_cnt >= CAP_FIRST) begin
        cap_q <= {cap_q[DATA_W-2:0], cipo};
      end
      if (state_q == GAP && state_d == IDLE) rdata_q <= cap_q;
    end
  end

  assign rdata = rdata_q;
`else
  logic unused_cipo;
  assign unused_cipo = cipo;
  assign rdata       = '0;
`endif

endmodule

// File: tb/tb_spi_reg_master.sv
// Self-checking bench for spi_reg_master: peripheral model with a frame scoreboard,
// table-driven frame vectors, and hand-written reset, back-to-back and CLK_DIV=1 sequences.
module tb_spi_reg_master;
  import spi_reg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, rw, cipo;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;
  logic       busy, done, sclk, copi, ncs;

  logic       start1;
  logic       busy1, done1, sclk1, copi1, ncs1;
  logic [7:0] rdata1;

  spi_reg_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .rdata(rdata)
  );

  spi_reg_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy1), .done(done1), .sclk(sclk1), .copi(copi1), .ncs(ncs1),
    .cipo(1'b0), .rdata(rdata1)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

`ifdef SPI_REG_MASTER_READBACK_EN
  localparam logic [7:0] EXP_RDATA = 8'h3C;
`else
  localparam logic [7:0] EXP_RDATA = 8'h00;
`endif

  // Peripheral model for the default instance, with scoreboard of expected frames.
  logic [15:0] exp_q[$];
  logic [15:0] rx;
  logic [7:0]  regs[128];
  logic [7:0]  rd_pat = 8'h3C;
  int          rise_cnt = 0;
  int          frames_rx = 0;
  bit          in_frame = 0;
  bit          abort_exp = 0;

  always @(negedge ncs) begin
    in_frame = 1;
    rx       = '0;
    rise_cnt = 0;
  end

  always @(posedge sclk) if (!ncs) begin
    rx = {rx[14:0], copi};
    rise_cnt++;
  end

  always @(negedge sclk) if (!ncs) begin
    cipo = (rise_cnt >= 8 && rise_cnt <= 15) ? rd_pat[15 - rise_cnt] : 1'b0;
  end

  always @(posedge ncs) if (in_frame) begin
    in_frame = 0;
    cipo     = 1'b0;
    if (abort_exp) begin
      abort_exp = 0;
      check("abort_rise_count", rise_cnt, 7);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      check("rise_count", rise_cnt, 16);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_frame: got 0x%0h, expected no frame", rx);
      end else begin
        check("frame", rx, exp_q.pop_front());
        frames_rx++;
        if (rx[15] == RW_WRITE) regs[rx[14:8]] = rx[7:0];
      end
    end
  end

  // Minimal receiver for the CLK_DIV=1 instance.
  logic [15:0] rx1;
  always @(negedge ncs1) rx1 = '0;
  always @(posedge sclk1) if (!ncs1) rx1 = {rx1[14:0], copi1};

  task automatic run_frame(
    input  logic        r,
    input  logic [6:0]  a,
    input  logic [7:0]  d,
    input  logic [15:0] exp_frame,
    input  int          inj,
    output int          lat,
    output int          low,
    output logic        busy_at_done
  );
    @(negedge clk);
    start = 1'b1; rw = r; addr = a; wdata = d;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back(exp_frame);
    rw = ~r; addr = ~a; wdata = ~d;
    lat = 0;
    low = ncs ? 0 : 1;
    while (!done && lat < 400) begin
      if (lat == inj) begin
        start = 1'b1; rw = 1'b1; addr = 7'h55; wdata = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (!ncs) low++;
    end
    start        = 1'b0;
    busy_at_done = busy;
  endtask

  typedef struct {
    logic        r;
    logic [6:0]  a;
    logic [7:0]  d;
    logic [15:0] frame;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   lat, low, w, gap, rises, first, last, n_before;
    logic bad, prev_busy, prev_s;

    vecs[0] = '{1'b1, 7'h04, 8'hA5, 16'h84A5};
    vecs[1] = '{1'b0, 7'h7F, 8'h00, 16'h7F00};
    vecs[2] = '{1'b1, 7'h2A, 8'h5A, 16'hAA5A};
    vecs[3] = '{1'b0, 7'h01, 8'hFF, 16'h01FF};

    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; cipo = 1'b0;
    rw = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ncs", ncs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_copi", copi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      n_before = frames_rx;
      run_frame(vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].frame, -1, lat, low, bad);
      check($sformatf("vec%0d_done_latency", i), lat, 140);
      check($sformatf("vec%0d_ncs_low", i), low, 136);
      check($sformatf("vec%0d_busy_at_done", i), bad, 0);
      check($sformatf("vec%0d_rdata", i), rdata, EXP_RDATA);
      check($sformatf("vec%0d_frames", i), frames_rx, n_before + 1);
    end
    check("reg_0x04", regs[7'h04], 8'hA5);
    check("reg_0x2a", regs[7'h2A], 8'h5A);

    // Start pulsed mid-frame is ignored: same frame, no second one.
    run_frame(1'b1, 7'h05, 8'h33, 16'h8533, 50, lat, low, bad);
    check("ign_done_latency", lat, 140);
    repeat (20) begin
      @(posedge clk); #1;
      if (!ncs || busy) bad = 1'b1;
    end
    check("ign_no_second_frame", bad, 0);
    check("ign_frames", frames_rx, 5);
    check("ign_reg", regs[7'h05], 8'h33);

    // Reset after the 7th rising edge.
    @(negedge clk);
    start = 1'b1; rw = 1'b1; addr = 7'h10; wdata = 8'h77;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back(16'h9077);
    abort_exp = 1;
    w = 0;
    while (rise_cnt < 7 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("abort_reached_edge7", rise_cnt, 7);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_ncs", ncs, 1);
    check("abort_sclk", sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_copi", copi, 0);
    check("abort_done", done, 0);
    check("abort_rdata", rdata, 0);
    @(negedge clk) rst_n = 1'b1;
    run_frame(1'b1, 7'h00, 8'h01, 16'h8001, -1, lat, low, bad);
    check("post_abort_latency", lat, 140);
    check("post_abort_reg0", regs[0], 8'h01);
    check("post_abort_reg10_untouched", regs[7'h10] === 8'h77, 0);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1; rw = 1'b1; addr = 7'h00; wdata = 8'hC0;
    prev_busy = busy;
    for (int i = 0; i < 5; i++) begin
      w = 0; gap = 0;
      do begin
        @(posedge clk); #1;
        w++;
        if (ncs) gap++;
        bad = busy && !prev_busy;
        prev_busy = busy;
      end while (!bad && w < 400);
      check($sformatf("b2b%0d_accepted", i), bad, 1);
      exp_q.push_back({1'b1, 7'(i), 8'(8'hC0 + i)});
      if (i > 0) check($sformatf("b2b%0d_ncs_gap", i), gap, 5);
      if (i == 4) start = 1'b0;
      addr  = 7'(i + 1);
      wdata = 8'(8'hC1 + i);
    end
    w = 0;
    while (!done && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    check("b2b_last_done", done, 1);
    for (int i = 0; i < 5; i++) check($sformatf("b2b_reg%0d", i), regs[i], 8'hC0 + 8'(i));

    // CLK_DIV = 1 instance.
    @(negedge clk);
    start1 = 1'b1; rw = 1'b1; addr = 7'h00; wdata = 8'hFF;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 0; rises = 0; first = -1; last = -1; prev_s = sclk1;
    while (!done1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (sclk1 && !prev_s) begin
        rises++;
        if (first < 0) first = lat;
        last = lat;
      end
      prev_s = sclk1;
    end
    check("div1_done_latency", lat, 35);
    check("div1_rises", rises, 16);
    check("div1_rise_span", last - first, 30);
    check("div1_frame", rx1, 16'h80FF);
    check("div1_busy_at_done", busy1, 0);
    check("div1_rdata", rdata1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
